mov_scheduler: RTL and testbench

MOV_SCHEDULER -- requirements
Module: mov_scheduler

---
 rtl/mov_scheduler.sv | 119 +++++++++++
 tb/tb_mov_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mov_scheduler.sv
// mov_scheduler: round-robin arbiter feeding a one-move-per-two-cycles register-file writer.
// Revision: 1.0
`default_nettype none

module mov_scheduler #(
  parameter int DATA_W = 16,
  parameter int N_REQ  = 4,
  parameter int N_REG  = 8,
  localparam int ID_W  = $clog2(N_REQ),
  localparam int IDX_W = $clog2(N_REG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_src,
  input  logic [N_REQ*IDX_W-1:0]  req_dst,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    mov_enable,
  output logic [DATA_W-1:0]       mov_src,
  output logic [IDX_W-1:0]        mov_dst,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  input  logic [IDX_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]       rd_data
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [DATA_W-1:0]  r_mov_src;
  logic [IDX_W-1:0]   r_mov_dst;
  logic [ID_W-1:0]    r_grant_id;
  logic [DATA_W-1:0]  r_regs [N_REG];

  logic               w_any;
  logic [ID_W-1:0]    w_winner;
  logic [N_REQ-1:0]   w_ready;
  logic               w_xfer;

  // Scan downward so the lowest offset from the pointer is the last (winning) assignment.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        w_any    = 1'b1;
        w_winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any && rst) begin
          w_ready[w_winner] = 1'b1;
          w_xfer            = 1'b1;
          w_state_nxt       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_mov_src  <= '0;
      r_mov_dst  <= '0;
      r_grant_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_mov_src  <= req_src[int'(w_winner)*DATA_W +: DATA_W];
        r_mov_dst  <= req_dst[int'(w_winner)*IDX_W +: IDX_W];
        r_grant_id <= w_winner;
        r_rr_ptr   <= ID_W'((int'(w_winner) + 1) % N_REQ);
      end
    end
  end

  // The write lands on the edge that closes ISSUE, so readers see the old value during ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == S_ISSUE) begin
      r_regs[r_mov_dst] <= r_mov_src;
    end
  end

  assign req_ready  = w_ready;
  assign mov_enable = (r_state == S_ISSUE);
  assign busy       = (r_state == S_ISSUE);
  assign mov_src    = r_mov_src;
  assign mov_dst    = r_mov_dst;
  assign grant_id   = r_grant_id;
  assign rd_data    = r_regs[rd_addr];

endmodule

`default_nettype wire

// File: tb/tb_mov_scheduler.sv
// tb_mov_scheduler: directed stimulus with a queue-based scoreboard on the move strobe.
`default_nettype none

module tb_mov_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_src;
  logic [11:0] req_dst;
  logic [3:0]  req_ready;
  logic        mov_enable;
  logic [15:0] mov_src;
  logic [2:0]  mov_dst;
  logic [1:0]  grant_id;
  logic        busy;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] src;
    logic [2:0]  dst;
  } mv_t;

  mv_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  mov_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst),
    .req_ready(req_ready), .mov_enable(mov_enable), .mov_src(mov_src), .mov_dst(mov_dst),
    .grant_id(grant_id), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] src, input logic [2:0] dst);
    req_src[i*16 +: 16] = src;
    req_dst[i*3 +: 3]   = dst;
  endtask

  task automatic push(input logic [1:0] id, input logic [15:0] src, input logic [2:0] dst);
    mv_t m;
    m.id  = id;
    m.src = src;
    m.dst = dst;
    exp_q.push_back(m);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
    rd_addr = a;
    #1;
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  // Monitor: every move strobe must match the next expected move in grant order.
  always @(negedge clk) begin
    if (rst && mov_enable) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_move: got id=%0d src=%0h dst=%0d expected none",
                 grant_id, mov_src, mov_dst);
      end else begin
        mv_t e;
        e = exp_q.pop_front();
        chk("move", {11'd0, grant_id, mov_src, mov_dst}, {11'd0, e.id, e.src, e.dst});
        chk("busy_in_issue", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_src   = '0;
    req_dst   = '0;
    rd_addr   = '0;
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_enable", 32'(mov_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", {11'd0, grant_id, mov_src, mov_dst}, 32'd0);
    tick();
    req_valid = 4'b0000;
    rst       = 1'b1;
    tick();

    // Single request from requester 2.
    set_req(2, 16'h000A, 3'd5);
    req_valid = 4'b0100;
    push(2'd2, 16'h000A, 3'd5);
    #1;
    chk("t1_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("t1_ready_issue", 32'(req_ready), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    rd_chk("t1_rd_old", 3'd5, 16'h0000);
    req_valid = 4'b0000;
    tick();
    chk("t1_busy_done", 32'(busy), 32'd0);
    rd_chk("t1_rd_new", 3'd5, 16'h000A);

    // Fresh reset, then all four requesters continuously valid.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rd_chk("t2_rd_cleared", 3'd5, 16'h0000);
    for (int i = 0; i < 4; i++) set_req(i, 16'h1000 + 16'(i), 3'(i));
    req_valid = 4'b1111;
    push(2'd0, 16'h1000, 3'd0);
    push(2'd1, 16'h1001, 3'd1);
    push(2'd2, 16'h1002, 3'd2);
    push(2'd3, 16'h1003, 3'd3);
    push(2'd0, 16'h1000, 3'd0);
    for (int c = 0; c < 10; c++) begin
      chk("t2_enable_cadence", 32'(mov_enable), 32'(c % 2));
      tick();
    end
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) rd_chk("t2_rd", 3'(i), 16'h1000 + 16'(i));

    // Requesters 1 and 3 both target register 7; the later grant wins.
    set_req(1, 16'hF00C, 3'd7);
    set_req(3, 16'hFFFF, 3'd7);
    req_valid = 4'b1010;
    push(2'd1, 16'hF00C, 3'd7);
    push(2'd3, 16'hFFFF, 3'd7);
    #1;
    chk("t3_ready1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    tick();
    chk("t3_ready3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0000;
    tick();
    rd_chk("t3_rd7", 3'd7, 16'hFFFF);

    // Request raised during ISSUE is held off until the following IDLE cycle.
    set_req(0, 16'h0055, 3'd4);
    set_req(1, 16'h0066, 3'd6);
    req_valid = 4'b0001;
    push(2'd0, 16'h0055, 3'd4);
    push(2'd1, 16'h0066, 3'd6);
    tick();
    req_valid = 4'b0011;
    #1;
    chk("t4_ready_issue", 32'(req_ready), 32'd0);
    req_valid = 4'b0010;
    tick();
    chk("t4_ready_idle", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    rd_chk("t4_rd4", 3'd4, 16'h0055);
    rd_chk("t4_rd6", 3'd6, 16'h0066);

    // Reset during ISSUE discards the pending write.
    set_req(2, 16'h1234, 3'd2);
    req_valid = 4'b0100;
    tick();
    chk("t5_busy", 32'(busy), 32'd1);
    req_valid = 4'b0000;
    rst       = 1'b0;
    #1;
    chk("t5_enable", 32'(mov_enable), 32'd0);
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_outs", {11'd0, grant_id, mov_src, mov_dst}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rd_chk("t5_rd2", 3'd2, 16'h0000);
    set_req(0, 16'h0A0A, 3'd1);
    set_req(3, 16'h0B0B, 3'd3);
    req_valid = 4'b1001;
    push(2'd0, 16'h0A0A, 3'd1);
    #1;
    chk("t5_first_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    tick();

    // Requester 0 withdraws before being served; pointer moves only for requester 1.
    set_req(1, 16'h00C1, 3'd5);
    set_req(2, 16'h00C2, 3'd0);
    req_valid = 4'b0011;
    push(2'd1, 16'h00C1, 3'd5);
    #1;
    chk("t6_ready1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    req_valid = 4'b0101;
    push(2'd2, 16'h00C2, 3'd0);
    #1;
    chk("t6_ready2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    rd_chk("t6_rd5", 3'd5, 16'h00C1);
    rd_chk("t6_rd0", 3'd0, 16'h00C2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
